// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and the iteration-counter width helper.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PREP = 2'b01,
      ST_RUN  = 2'b10,
      ST_FIX  = 2'b11
   } state_e;

   localparam int DEF_WIDTH = 32;

   // Counter must be able to hold 0..WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: one shift-add (multiply) or one restoring-division
// step per cycle on a 2*WIDTH accumulator, plus the iteration counter.
// Accumulator layout: multiply {product_hi, product_lo}; divide {remainder, quotient}.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] acc,
   output logic               last
);

   localparam int CW = cnt_width(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;

   // Next-state of accumulator, operand register and counter.
   always_comb begin
      acc_d    = acc_q;
      dsr_d    = dsr_q;
      cnt_d    = cnt_q;
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, dsr_q};
      if (load) begin
         acc_d = {{WIDTH{1'b0}}, opa};
         dsr_d = opb;
         cnt_d = '0;
      end else if (step) begin
         cnt_d = cnt_q + 1'b1;
         if (is_div) begin
            if (rem_sh >= {1'b0, dsr_q})
               acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end else begin
            if (acc_q[0])
               mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dsr_q};
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         dsr_q <= dsr_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc  = acc_q;
   assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_hilo.sv
// Multiply/divide unit with HI/LO registers: FSM, sign handling,
// result fix-up and HI/LO write priority (FIX result beats MTHI/MTLO).
module muldiv_hilo
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wena_hi,
   input  logic             wena_lo,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic             is_signed, is_div;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             core_load, core_step, core_last;
   logic [2*WIDTH-1:0] core_acc;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign is_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (core_load),
      .step   (core_step),
      .is_div (is_div),
      .opa    (mag_a),
      .opb    (mag_b),
      .acc    (core_acc),
      .last   (core_last)
   );

   // Operand magnitudes fed to the core during PREP.
   always_comb begin
      mag_a = a_q;
      mag_b = b_q;
      if (is_signed && a_q[WIDTH-1]) mag_a = -a_q;
      if (is_signed && b_q[WIDTH-1]) mag_b = -b_q;
   end

   // Sign correction and divide-by-zero override of the raw core result.
   always_comb begin
      prod = core_acc;
      quo  = core_acc[WIDTH-1:0];
      rem  = core_acc[2*WIDTH-1:WIDTH];
      if (op_q == OP_MULT && (sign_a_q ^ sign_b_q)) prod = -core_acc;
      if (op_q == OP_DIV) begin
         if (sign_a_q ^ sign_b_q) quo = -core_acc[WIDTH-1:0];
         if (sign_a_q)            rem = -core_acc[2*WIDTH-1:WIDTH];
      end
      if (is_div) begin
         res_hi = rem;
         res_lo = quo;
         if (dbz_q) begin
            res_hi = a_q;
            res_lo = '1;
         end
      end else begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end
   end

   // FSM next-state, operand capture and HI/LO write priority.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      hi_d      = wena_hi ? hi_in : hi_q;
      lo_d      = wena_lo ? lo_in : lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op_e'(op);
               a_d     = a;
               b_d     = b;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            sign_a_d  = is_signed & a_q[WIDTH-1];
            sign_b_d  = is_signed & b_q[WIDTH-1];
            dbz_d     = is_div && (b_q == '0);
            core_load = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            core_step = 1'b1;
            if (core_last) state_d = ST_FIX;
         end
         ST_FIX: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and architectural registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MULT;
         a_q      <= '0;
         b_q      <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         dbz_q    <= dbz_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed bench for muldiv_hilo with hand-computed expected results.
module tb_muldiv_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b, hi_in, lo_in;
   logic        wena_hi, wena_lo;
   logic        busy, done;
   logic [31:0] hi_out, lo_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_hilo #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .wena_hi (wena_hi),
      .wena_lo (wena_lo),
      .hi_in   (hi_in),
      .lo_in   (lo_in),
      .busy    (busy),
      .done    (done),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

   // Called 1 time unit after an edge with the DUT idle; returns 1 unit after E0.
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = 2'b00; a = '0; b = '0;
   endtask

   // Waits (bounded) for done; lat = edges after E0 at which done is seen.
   // inj_kind 0: pulse start with a=b=9; inj_kind 1: MTLO 0x55. lo_snap = lo_out after injection edge.
   task automatic wait_done(input int inj_cyc, input int inj_kind, output int lat,
                            output logic busy_ok, output logic [31:0] lo_snap);
      lat = -1; busy_ok = 1'b1; lo_snap = '0;
      for (int k = 1; k <= 60; k++) begin
         if (k == inj_cyc) begin
            if (inj_kind == 0) begin
               start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
            end else begin
               wena_lo = 1'b1; lo_in = 32'h55;
            end
         end
         @(posedge clk); #1;
         start = 1'b0; wena_lo = 1'b0; a = '0; b = '0;
         if (k == inj_cyc) lo_snap = lo_out;
         if (done) begin
            lat = k;
            if (busy) busy_ok = 1'b0;
            break;
         end else if (!busy) busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      wena_hi = 1'b0; wena_lo = 1'b0; hi_in = '0; lo_in = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", hi_out, 32'h0); end
      n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", lo_out, 32'h0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_multu();
      int lat; logic bok; logic [31:0] snap;
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL multu_latency: got %0d want 34", lat); end
      n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL multu_busy_window: got %b want 1", bok); end
      n_cmp++; if (hi_out !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want %h", hi_out, 32'hFFFF_FFFE); end
      n_cmp++; if (lo_out !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want %h", lo_out, 32'h0000_0001); end
   endtask

   task automatic test_signed();
      int lat; logic bok; logic [31:0] snap;
      launch(2'b00, 32'hFFFF_FFFD, 32'd5);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want %h", hi_out, 32'hFFFF_FFFF); end
      n_cmp++; if (lo_out !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_lo: got %h want %h", lo_out, 32'hFFFF_FFF1); end
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lo_out !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want %h", lo_out, 32'hFFFF_FFFD); end
      n_cmp++; if (hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want %h", hi_out, 32'hFFFF_FFFF); end
      launch(2'b11, 32'd7, 32'd2);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lo_out !== 32'd3) begin n_bad++; $display("FAIL divu_lo: got %h want %h", lo_out, 32'd3); end
      n_cmp++; if (hi_out !== 32'd1) begin n_bad++; $display("FAIL divu_hi: got %h want %h", hi_out, 32'd1); end
   endtask

   task automatic test_div_edge();
      int lat; logic bok; logic [31:0] snap;
      launch(2'b10, 32'h1234_5678, 32'h0);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL dbz_latency: got %0d want 34", lat); end
      n_cmp++; if (lo_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_lo: got %h want %h", lo_out, 32'hFFFF_FFFF); end
      n_cmp++; if (hi_out !== 32'h1234_5678) begin n_bad++; $display("FAIL dbz_hi: got %h want %h", hi_out, 32'h1234_5678); end
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lo_out !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_lo: got %h want %h", lo_out, 32'h8000_0000); end
      n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL ovf_hi: got %h want %h", hi_out, 32'h0); end
   endtask

   task automatic test_mt();
      int lat; logic bok; logic [31:0] snap;
      wena_hi = 1'b1; hi_in = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      wena_hi = 1'b0;
      n_cmp++; if (hi_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mthi_idle: got %h want %h", hi_out, 32'hDEAD_BEEF); end
      n_cmp++; if (lo_out !== 32'h8000_0000) begin n_bad++; $display("FAIL mthi_lo_kept: got %h want %h", lo_out, 32'h8000_0000); end
      launch(2'b00, 32'd2, 32'd3);
      wait_done(3, 1, lat, bok, snap);
      n_cmp++; if (snap !== 32'h55) begin n_bad++; $display("FAIL mtlo_busy: got %h want %h", snap, 32'h55); end
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL mt_mult_latency: got %0d want 34", lat); end
      n_cmp++; if (lo_out !== 32'd6) begin n_bad++; $display("FAIL mt_mult_lo: got %h want %h", lo_out, 32'd6); end
      n_cmp++; if (hi_out !== 32'd0) begin n_bad++; $display("FAIL mt_mult_hi: got %h want %h", hi_out, 32'd0); end
   endtask

   task automatic test_back_to_back();
      int lat; logic bok; logic [31:0] snap;
      launch(2'b01, 32'd3, 32'd4);
      wait_done(5, 0, lat, bok, snap);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL ignored_latency: got %0d want 34", lat); end
      n_cmp++; if (bok !== 1'b1) begin n_bad++; $display("FAIL ignored_busy_window: got %b want 1", bok); end
      n_cmp++; if (hi_out !== 32'd0) begin n_bad++; $display("FAIL ignored_hi: got %h want %h", hi_out, 32'd0); end
      n_cmp++; if (lo_out !== 32'd12) begin n_bad++; $display("FAIL ignored_lo: got %h want %h", lo_out, 32'd12); end
      // Still inside the done cycle: this start must be accepted.
      launch(2'b01, 32'd7, 32'd6);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d want 34", lat); end
      n_cmp++; if (lo_out !== 32'd42) begin n_bad++; $display("FAIL b2b_lo: got %h want %h", lo_out, 32'd42); end
   endtask

   task automatic test_reset_abort();
      int lat; logic bok; logic [31:0] snap; int pulses;
      wena_hi = 1'b1; hi_in = 32'hA5;
      launch(2'b10, 32'd100, 32'd3);
      wena_hi = 1'b0;
      n_cmp++; if (hi_out !== 32'hA5) begin n_bad++; $display("FAIL start_with_mthi: got %h want %h", hi_out, 32'hA5); end
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL abort_hi: got %h want %h", hi_out, 32'h0); end
      n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL abort_lo: got %h want %h", lo_out, 32'h0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
      launch(2'b11, 32'd100, 32'd7);
      wait_done(0, 0, lat, bok, snap);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL post_abort_latency: got %0d want 34", lat); end
      n_cmp++; if (lo_out !== 32'd14) begin n_bad++; $display("FAIL post_abort_lo: got %h want %h", lo_out, 32'd14); end
      n_cmp++; if (hi_out !== 32'd2) begin n_bad++; $display("FAIL post_abort_hi: got %h want %h", hi_out, 32'd2); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_signed();
      test_div_edge();
      test_mt();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
